// File: rtl/arbiter_pkg.sv
// Shared FSM state encodings and requester IDs for the instruction/data cache memory arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_priority_select.sv
// Picks the winning requester from two request lines.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants; otherwise the data cache has fixed priority.
module arb_priority_select
  import arbiter_pkg::*;
(
  input  logic    icache_req_i,
  input  logic    dcache_req_i,
  input  req_id_e last_grant_i,
  output req_id_e grant_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_o = ICACHE;
    if (icache_req_i && dcache_req_i) begin
      // On contention, favour whoever was not served last.
      if (last_grant_i == ICACHE) begin
        grant_o = DCACHE;
      end else begin
        grant_o = ICACHE;
      end
    end else if (dcache_req_i) begin
      grant_o = DCACHE;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o = ICACHE;
    if (dcache_req_i) begin
      grant_o = DCACHE;
    end
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data cache requests onto one shared memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention handling (default: data cache priority).
module memory_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_read_request,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic [DATA_WIDTH-1:0] icache_read_data,
  output logic                  icache_response,
  input  logic                  dcache_read_request,
  input  logic                  dcache_write_request,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [DATA_WIDTH-1:0] dcache_write_data,
  output logic [DATA_WIDTH-1:0] dcache_read_data,
  output logic                  dcache_response,
  output logic                  memory_read_request,
  output logic                  memory_write_request,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  input  logic                  memory_response
);

  arb_state_e            state_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] icache_rdata_q;
  logic [DATA_WIDTH-1:0] dcache_rdata_q;
  logic                  icache_resp_q;
  logic                  dcache_resp_q;

  logic    dcache_req;
  req_id_e grant_d;
  req_id_e last_grant;

  assign dcache_req = dcache_read_request | dcache_write_request;

  arb_priority_select u_select (
    .icache_req_i (icache_read_request),
    .dcache_req_i (dcache_req),
    .last_grant_i (last_grant),
    .grant_o      (grant_d)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q;
  assign last_grant = last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ICACHE;
    end else if (state_q == IDLE && (icache_read_request || dcache_req)) begin
      last_grant_q <= grant_d;
    end
  end
`else
  assign last_grant = ICACHE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      icache_rdata_q <= '0;
      dcache_rdata_q <= '0;
      icache_resp_q  <= 1'b0;
      dcache_resp_q  <= 1'b0;
    end else begin
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (icache_read_request || dcache_req) begin
            if (grant_d == DCACHE) begin
              // A simultaneous read and write resolves to the write.
              state_q     <= BUSY_D;
              mem_addr_q  <= dcache_addr;
              mem_wdata_q <= dcache_write_data;
              mem_wr_q    <= dcache_write_request;
              mem_rd_q    <= ~dcache_write_request;
            end else begin
              state_q     <= BUSY_I;
              mem_addr_q  <= icache_addr;
              mem_wdata_q <= '0;
              mem_wr_q    <= 1'b0;
              mem_rd_q    <= 1'b1;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (memory_response) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            state_q  <= DONE;
            if (state_q == BUSY_I) begin
              icache_rdata_q <= memory_read_data;
              icache_resp_q  <= 1'b1;
            end else begin
              dcache_rdata_q <= memory_read_data;
              dcache_resp_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign icache_read_data     = icache_rdata_q;
  assign icache_response      = icache_resp_q;
  assign dcache_read_data     = dcache_rdata_q;
  assign dcache_response      = dcache_resp_q;
  assign memory_read_request  = mem_rd_q;
  assign memory_write_request = mem_wr_q;
  assign memory_addr          = mem_addr_q;
  assign memory_write_data    = mem_wdata_q;

endmodule
